m_issue_ctrl: RTL and testbench
===============================

// Module: m_issue_ctrl
// PURPOSE
//  EX-stage sequencer in front of the M-extension unit (mul/div). Captures operands of an
//  RV32M op from the ID/EX register and drives start/operands to the unit. Stalls the
//  pipeline until the unit responds, then presents one registered writeback beat.
//  Resolves divide-by-zero and signed overflow locally without starting the unit.
// PARAMETERS
//  TIMEOUT   64   max BUSY cycles without m_resp before timeout_err sets (sticky)
//  CNT_W     16   width of busy-cycle performance counter
// PORTS
//  clk          in   1      clock; single clock domain
//  rst          in   1      reset; asynchronous, active-low
//  op_valid     in   1      EX holds an RV32M instruction
//  funct3       in   3      000 mul,001 mulh,010 mulhsu,011 mulhu,100 div,101 divu,110 rem,111 remu
//  rs1_data     in   32     operand a
//  rs2_data     in   32     operand b
//  rd_addr      in   5      destination register
//  flush        in   1      squash EX (branch/trap); overrides op_valid
//  m_resp       in   1      unit result valid (level, while start held)
//  m_f          in   32     unit result
//  unit_start   out  1      held high while unit must compute
//  unit_a       out  32     latched operand a
//  unit_b       out  32     latched operand b
//  unit_funct3  out  3      latched funct3
//  stall        out  1      freeze PC/IF/ID/EX regs (combinational)
//  wb_valid     out  1      one-cycle writeback beat
//  wb_rd        out  5      writeback register
//  wb_data      out  32     writeback value
//  timeout_err  out  1      sticky; cleared only by reset
//  busy_cycles  out  CNT_W  saturating count of cycles spent in BUSY
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs and latches 0; counters 0.
//  States IDLE, BUSY, DONE. Transitions on rising clk:
//   IDLE: op_valid & ~flush -> latch funct3/a/b/rd. If special case -> DONE with local result,
//         else -> BUSY. Otherwise stay.
//   BUSY: unit_start=1. flush -> IDLE (unit_start drops next cycle, result discarded).
//         m_resp -> latch m_f into wb_data -> DONE. Else stay; busy_cycles++ (saturate).
//   DONE: wb_valid=1 for exactly this cycle -> IDLE. op_valid ignored in DONE.
//  stall = (IDLE & op_valid & ~flush) | BUSY. Low in DONE so pipeline advances then.
//  Special cases (funct3[2]=1), on latched operands:
//   b==0: div/divu -> 32'hFFFF_FFFF; rem/remu -> a.
//   div a==32'h8000_0000 & b==32'hFFFF_FFFF -> 32'h8000_0000; rem same operands -> 0.
//   divu/remu never overflow. Special cases take 1 cycle: wb_valid in cycle N+1 after capture N.
//  Normal latency: wb_valid exactly 1 cycle after the cycle m_resp is sampled high.
//  m_resp outside BUSY ignored. Flush in DONE does not suppress wb_valid (already committed).
//  rd_addr==0: full sequence still runs; wb_valid asserted, regfile discards it.
//  Timeout: BUSY for TIMEOUT consecutive cycles sets timeout_err; FSM keeps waiting.
//  unit_a/unit_b/unit_funct3 stable for the whole BUSY interval.
//  Deasserting unit_start for >=1 cycle aborts the unit; no back-to-back start without IDLE gap.
// TESTING
//  mul a=7,b=6; m_resp after 3 cycles, m_f=42 -> stall 4 cycles, wb_valid next cycle, wb_data=42.
//  div a=100,b=0 -> unit_start never high, wb_valid at N+1, wb_data=32'hFFFF_FFFF.
//  rem a=32'h8000_0000,b=-1 -> no unit start, wb_data=0; div same -> 32'h8000_0000.
//  divu a=32'h8000_0000,b=-1 -> goes BUSY (no overflow shortcut); wb_data=m_f.
//  flush 2 cycles into BUSY, then m_resp -> IDLE, no wb_valid, stall low.
//  m_resp withheld 64 cycles -> timeout_err=1; rst low mid-BUSY -> all outputs 0 at once.

Source files
------------

// File: rtl/m_issue_ctrl.sv
// EX-stage sequencer for the RV32M mul/div unit.
// Resolves div-by-zero/overflow locally, else waits for the unit.
module m_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [2:0]       funct3,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [4:0]       rd_addr,
  input  logic             flush,
  input  logic             m_resp,
  input  logic [31:0]      m_f,
  output logic             unit_start,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  output logic [2:0]       unit_funct3,
  output logic             stall,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             timeout_err,
  output logic [CNT_W-1:0] busy_cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [1:0]       st_q, st_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [2:0]       f3_q, f3_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      wbd_q, wbd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             to_q, to_d;

  logic        b_zero;
  logic        ovf;
  logic        special;
  logic [31:0] spec_res;

  // Detect the cases the unit is never asked to compute.
  always_comb begin
    b_zero  = (rs2_data == 32'h0);
    ovf     = ~funct3[0]
            & (rs1_data == 32'h8000_0000)
            & (rs2_data == 32'hFFFF_FFFF);
    special = funct3[2] & (b_zero | ovf);
    if (b_zero) begin
      spec_res = funct3[1] ? rs1_data : 32'hFFFF_FFFF;
    end else begin
      spec_res = funct3[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // Next-state, operand capture, and BUSY bookkeeping.
  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    f3_d  = f3_q;
    rd_d  = rd_q;
    wbd_d = wbd_q;
    cnt_d = cnt_q;
    tmo_d = '0;
    to_d  = to_q;
    case (st_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          a_d  = rs1_data;
          b_d  = rs2_data;
          f3_d = funct3;
          rd_d = rd_addr;
          if (special) begin
            wbd_d = spec_res;
            st_d  = S_DONE;
          end else begin
            st_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          st_d = S_IDLE;
        end else if (m_resp) begin
          wbd_d = m_f;
          st_d  = S_DONE;
        end else begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          tmo_d = tmo_q;
          if (tmo_q != TMO_W'(TIMEOUT)) begin
            tmo_d = tmo_q + 1'b1;
          end
          if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            to_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        st_d = S_IDLE;
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q  <= S_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      f3_q  <= '0;
      rd_q  <= '0;
      wbd_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      to_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      f3_q  <= f3_d;
      rd_q  <= rd_d;
      wbd_q <= wbd_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      to_q  <= to_d;
    end
  end

  // Outputs decoded from state and latched fields.
  always_comb begin
    unit_start  = (st_q == S_BUSY);
    unit_a      = a_q;
    unit_b      = b_q;
    unit_funct3 = f3_q;
    stall       = ((st_q == S_IDLE) & op_valid & ~flush)
                | (st_q == S_BUSY);
    wb_valid    = (st_q == S_DONE);
    wb_rd       = rd_q;
    wb_data     = wbd_q;
    timeout_err = to_q;
    busy_cycles = cnt_q;
  end

endmodule

// File: tb/tb_m_issue_ctrl.sv
// Directed bench for m_issue_ctrl.
// Linear stimulus, immediate-assert checks.
module tb_m_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        op_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        m_resp;
  logic [31:0] m_f;
  logic        unit_start;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic [2:0]  unit_funct3;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout_err;
  logic [15:0] busy_cycles;

  int vectors;
  int miscompares;

  m_issue_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .funct3      (funct3),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .rd_addr     (rd_addr),
    .flush       (flush),
    .m_resp      (m_resp),
    .m_f         (m_f),
    .unit_start  (unit_start),
    .unit_a      (unit_a),
    .unit_b      (unit_b),
    .unit_funct3 (unit_funct3),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .timeout_err (timeout_err),
    .busy_cycles (busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_spec(input string tag,
                         input logic [2:0]  f,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0]  rd,
                         input logic [31:0] exp);
    op_valid = 1'b1;
    funct3   = f;
    rs1_data = a;
    rs2_data = b;
    rd_addr  = rd;
    #1;
    chk({tag, "_stall_cap"}, 32'(stall), 32'd1);
    tick();
    op_valid = 1'b0;
    flush    = 1'b1;
    #1;
    chk({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    chk({tag, "_data"}, wb_data, exp);
    chk({tag, "_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_nostart"}, 32'(unit_start), 32'd0);
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk({tag, "_wbv_off"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst      = 1'b0;
    op_valid = 1'b0;
    funct3   = 3'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    rd_addr  = 5'd0;
    flush    = 1'b0;
    m_resp   = 1'b0;
    m_f      = 32'd0;
    #12;
    chk("rst_start", 32'(unit_start), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_data", wb_data, 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_cnt", 32'(busy_cycles), 32'd0);
    rst = 1'b1;
    tick();

    // mul 7*6, unit answers in 3rd BUSY cycle
    op_valid = 1'b1;
    funct3   = 3'b000;
    rs1_data = 32'd7;
    rs2_data = 32'd6;
    rd_addr  = 5'd5;
    #1;
    chk("mul_stall0", 32'(stall), 32'd1);
    tick();
    op_valid = 1'b0;
    #1;
    chk("mul_start", 32'(unit_start), 32'd1);
    chk("mul_a", unit_a, 32'd7);
    chk("mul_b", unit_b, 32'd6);
    chk("mul_f3", 32'(unit_funct3), 32'd0);
    chk("mul_stall1", 32'(stall), 32'd1);
    tick();
    chk("mul_stall2", 32'(stall), 32'd1);
    tick();
    m_resp = 1'b1;
    m_f    = 32'd42;
    #1;
    chk("mul_stall3", 32'(stall), 32'd1);
    tick();
    m_resp = 1'b0;
    m_f    = 32'd0;
    #1;
    chk("mul_wbv", 32'(wb_valid), 32'd1);
    chk("mul_data", wb_data, 32'd42);
    chk("mul_rd", 32'(wb_rd), 32'd5);
    chk("mul_stall_done", 32'(stall), 32'd0);
    chk("mul_start_done", 32'(unit_start), 32'd0);
    chk("mul_cnt", 32'(busy_cycles), 32'd2);
    tick();
    chk("mul_wbv_off", 32'(wb_valid), 32'd0);

    // local results: div/rem by zero and signed overflow
    do_spec("div0", 3'b100, 32'd100, 32'd0, 5'd3, 32'hFFFF_FFFF);
    do_spec("divu0", 3'b101, 32'd9, 32'd0, 5'd4, 32'hFFFF_FFFF);
    do_spec("remu0", 3'b111, 32'h1234, 32'd0, 5'd6, 32'h1234);
    do_spec("rem0", 3'b110, 32'hF000_0001, 32'd0, 5'd7, 32'hF000_0001);
    do_spec("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0);
    do_spec("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000);

    // divu with overflow-looking operands must use the unit
    op_valid = 1'b1;
    funct3   = 3'b101;
    rs1_data = 32'h8000_0000;
    rs2_data = 32'hFFFF_FFFF;
    rd_addr  = 5'd9;
    tick();
    op_valid = 1'b0;
    #1;
    chk("divu_start", 32'(unit_start), 32'd1);
    chk("divu_f3", 32'(unit_funct3), 32'd5);
    m_resp = 1'b1;
    m_f    = 32'd0;
    tick();
    m_resp = 1'b0;
    #1;
    chk("divu_wbv", 32'(wb_valid), 32'd1);
    chk("divu_data", wb_data, 32'd0);
    chk("divu_cnt", 32'(busy_cycles), 32'd2);
    tick();

    // stray m_resp in IDLE is ignored
    m_resp = 1'b1;
    m_f    = 32'h55;
    tick();
    m_resp = 1'b0;
    #1;
    chk("idle_resp_wbv", 32'(wb_valid), 32'd0);
    chk("idle_resp_stall", 32'(stall), 32'd0);

    // flush in IDLE blocks capture
    op_valid = 1'b1;
    flush    = 1'b1;
    funct3   = 3'b011;
    rs1_data = 32'd3;
    rs2_data = 32'd4;
    #1;
    chk("iflush_stall", 32'(stall), 32'd0);
    tick();
    chk("iflush_start", 32'(unit_start), 32'd0);
    flush = 1'b0;

    // flush two cycles into BUSY, late m_resp discarded
    tick();
    op_valid = 1'b0;
    #1;
    chk("bflush_start", 32'(unit_start), 32'd1);
    tick();
    flush = 1'b1;
    tick();
    flush  = 1'b0;
    m_resp = 1'b1;
    m_f    = 32'd99;
    #1;
    chk("bflush_start_off", 32'(unit_start), 32'd0);
    chk("bflush_stall", 32'(stall), 32'd0);
    chk("bflush_wbv", 32'(wb_valid), 32'd0);
    tick();
    m_resp = 1'b0;
    #1;
    chk("bflush_wbv2", 32'(wb_valid), 32'd0);
    chk("bflush_cnt", 32'(busy_cycles), 32'd3);

    // timeout after 64 silent BUSY cycles
    op_valid = 1'b1;
    funct3   = 3'b001;
    rs1_data = 32'hA5A5_0001;
    rs2_data = 32'h0000_0011;
    rd_addr  = 5'd10;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 63; i++) tick();
    chk("tmo_before", 32'(timeout_err), 32'd0);
    tick();
    chk("tmo_set", 32'(timeout_err), 32'd1);
    chk("tmo_wait", 32'(unit_start), 32'd1);
    chk("tmo_a", unit_a, 32'hA5A5_0001);
    chk("tmo_cnt", 32'(busy_cycles), 32'd67);
    tick();
    chk("tmo_sticky", 32'(timeout_err), 32'd1);

    // async reset mid-BUSY
    #2;
    rst = 1'b0;
    #1;
    chk("arst_start", 32'(unit_start), 32'd0);
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_tmo", 32'(timeout_err), 32'd0);
    chk("arst_cnt", 32'(busy_cycles), 32'd0);
    chk("arst_a", unit_a, 32'd0);
    chk("arst_data", wb_data, 32'd0);
    rst = 1'b1;
    tick();
    do_spec("post", 3'b100, 32'd1, 32'd0, 5'd1, 32'hFFFF_FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
